// File: rtl/order_scheduler.sv
// Sequences host/panel motor-DAC orders into SendingUnit, round-robin, one at a time.
// Latency: grant and command strobe one cycle after the request is sampled; all outputs registered.
// Backpressure: send_ready=0 stalls arbitration, WAIT holds until send_done; requests stay pending.
// Optional macro ORDER_TIMEOUT_EN: WAIT watchdog of TIMEOUT cycles with sticky timeout_err.
module order_scheduler #(
  parameter int AMT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             host_req,
  input  logic [2:0]       host_cmd,
  input  logic [AMT_W-1:0] host_amt,
  output logic             host_gnt,
  input  logic             pnl_req,
  input  logic [2:0]       pnl_cmd,
  input  logic [AMT_W-1:0] pnl_amt,
  output logic             pnl_gnt,
  input  logic             send_ready,
  input  logic             send_done,
  output logic             ValidSignal,
  output logic [AMT_W-1:0] AmountSignal,
  output logic             increaseSignal,
  output logic             decreaseSignal,
  output logic             onSignal,
  output logic             offSignal,
  output logic             busy,
  output logic             last_src,
  output logic             cmd_err,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [2:0] CMD_ON  = 3'd0;
  localparam logic [2:0] CMD_OFF = 3'd1;
  localparam logic [2:0] CMD_INC = 3'd2;
  localparam logic [2:0] CMD_DEC = 3'd3;
  localparam logic [2:0] CMD_SET = 3'd4;

  // A zero limit would mean leaving WAIT before it was entered.
  if (TIMEOUT < 1) begin : g_timeout_range
    $error("order_scheduler: TIMEOUT must be at least 1");
  end

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       cmd_q;
  logic [2:0]       cmd_nxt;
  logic [AMT_W-1:0] amt_nxt;
  logic             last_src_nxt;
  logic             host_gnt_nxt;
  logic             pnl_gnt_nxt;
  logic             on_nxt;
  logic             off_nxt;
  logic             inc_nxt;
  logic             dec_nxt;
  logic             valid_nxt;
  logic             cmd_err_nxt;
  logic             busy_nxt;
  logic             pick_pnl;
  logic [2:0]       win_cmd;
  logic [AMT_W-1:0] win_amt;

`ifdef ORDER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             tmo_hit;

  assign cnt_inc = cnt + CNT_W'(1);
`endif

  // Winner selection: a lone requester wins, a tie goes to the source not served last.
  always_comb begin
    pick_pnl = pnl_req && (!host_req || !last_src);
    win_cmd  = pick_pnl ? pnl_cmd : host_cmd;
    win_amt  = pick_pnl ? pnl_amt : host_amt;
  end

  // Next-state and next-output decode; every output is the registered copy of these values.
  always_comb begin
    state_nxt    = state;
    cmd_nxt      = cmd_q;
    amt_nxt      = AmountSignal;
    last_src_nxt = last_src;
    host_gnt_nxt = 1'b0;
    pnl_gnt_nxt  = 1'b0;
    on_nxt       = 1'b0;
    off_nxt      = 1'b0;
    inc_nxt      = 1'b0;
    dec_nxt      = 1'b0;
    valid_nxt    = 1'b0;
    cmd_err_nxt  = 1'b0;
`ifdef ORDER_TIMEOUT_EN
    tmo_hit      = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (send_ready && (host_req || pnl_req)) begin
          state_nxt    = S_ISSUE;
          cmd_nxt      = win_cmd;
          last_src_nxt = pick_pnl;
          host_gnt_nxt = !pick_pnl;
          pnl_gnt_nxt  = pick_pnl;
          case (win_cmd)
            CMD_ON:  on_nxt  = 1'b1;
            CMD_OFF: off_nxt = 1'b1;
            CMD_INC: inc_nxt = 1'b1;
            CMD_DEC: dec_nxt = 1'b1;
            CMD_SET: begin
              valid_nxt = 1'b1;
              amt_nxt   = win_amt;
            end
            default: cmd_err_nxt = 1'b1;
          endcase
        end
      end
      S_ISSUE: begin
        // An illegal code produced no strobe, so there is nothing to wait for.
        state_nxt = (cmd_q > CMD_SET) ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (send_done) begin
          state_nxt = S_IDLE;
        end
`ifdef ORDER_TIMEOUT_EN
        else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          state_nxt = S_IDLE;
          tmo_hit   = 1'b1;
        end
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cmd_q          <= 3'd0;
      AmountSignal   <= '0;
      last_src       <= 1'b1;
      host_gnt       <= 1'b0;
      pnl_gnt        <= 1'b0;
      onSignal       <= 1'b0;
      offSignal      <= 1'b0;
      increaseSignal <= 1'b0;
      decreaseSignal <= 1'b0;
      ValidSignal    <= 1'b0;
      cmd_err        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      cmd_q          <= cmd_nxt;
      AmountSignal   <= amt_nxt;
      last_src       <= last_src_nxt;
      host_gnt       <= host_gnt_nxt;
      pnl_gnt        <= pnl_gnt_nxt;
      onSignal       <= on_nxt;
      offSignal      <= off_nxt;
      increaseSignal <= inc_nxt;
      decreaseSignal <= dec_nxt;
      ValidSignal    <= valid_nxt;
      cmd_err        <= cmd_err_nxt;
      busy           <= busy_nxt;
    end
  end

`ifdef ORDER_TIMEOUT_EN
  // WAIT watchdog: zero outside WAIT so every WAIT entry starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state != S_WAIT) begin
      cnt <= '0;
    end else if (!send_done) begin
      cnt <= cnt_inc;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else if (tmo_hit) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule
